multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle RV32I main control unit: a registered FSM that sequences FETCH/DECODE/EXEC/MEM/WB
//  per instruction and drives datapath enables per state. Adds memory ready handshakes, a

---
 rtl/multicycle_ctrl_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// enables, and adds ready handshakes, a wait timeout, an illegal-opcode trap and a retire counter.
module multicycle_ctrl_fsm #(
  parameter int OPC_W   = 7,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             stall,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             trap,
  output logic             bus_err
);

  localparam logic [OPC_W-1:0] OP_R     = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] OP_IMM   = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(7'b0100011);
  localparam logic [OPC_W-1:0] OP_BR    = OPC_W'(7'b1100011);
  localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(7'b1101111);
  localparam logic [OPC_W-1:0] OP_JALR  = OPC_W'(7'b1100111);
  localparam logic [OPC_W-1:0] OP_AUIPC = OPC_W'(7'b0010111);
  localparam logic [OPC_W-1:0] OP_LUI   = OPC_W'(7'b0110111);

  localparam int TMAX   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int WAIT_W = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
  localparam logic [WAIT_W-1:0] TMAX_W = WAIT_W'(TMAX);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  state_t             state;
  logic [OPC_W-1:0]   op_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               pc_write_q;
  logic [1:0]         pc_sel_q;
  logic               br_exec;

  logic is_r, is_imm, is_load, is_store, is_br, is_jal, is_jalr, is_auipc, is_lui, legal;
  logic [1:0] alu_op_n, wb_sel_n, pc_sel_n;
  logic timeout_hit;

  // Class decode works only on the latched opcode, never on the live imem bus.
  always_comb begin
    is_r     = (op_q == OP_R);
    is_imm   = (op_q == OP_IMM);
    is_load  = (op_q == OP_LOAD);
    is_store = (op_q == OP_STORE);
    is_br    = (op_q == OP_BR);
    is_jal   = (op_q == OP_JAL);
    is_jalr  = (op_q == OP_JALR);
    is_auipc = (op_q == OP_AUIPC);
    is_lui   = (op_q == OP_LUI);
    legal    = is_r | is_imm | is_load | is_store | is_br | is_jal | is_jalr | is_auipc | is_lui;
    alu_op_n = is_r ? 2'b10 : is_imm ? 2'b11 : is_br ? 2'b01 : 2'b00;
    wb_sel_n = (is_jal | is_jalr) ? 2'b01 : is_lui ? 2'b10 : is_auipc ? 2'b11 : 2'b00;
    pc_sel_n = is_jal ? 2'b10 : is_jalr ? 2'b11 : 2'b00;
  end

  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == TMAX_W);

  // Handshake-dependent pulses: registered state flags qualified by the ready/compare inputs.
  assign ir_write   = imem_req & imem_ready;
  assign pc_write   = pc_write_q | br_exec | (mem_write & dmem_ready);
  assign instr_done = pc_write;
  assign pc_sel     = br_exec ? {1'b0, branch_taken} : pc_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      op_q        <= '0;
      wait_cnt    <= '0;
      retired_cnt <= '0;
      trap        <= 1'b0;
      bus_err     <= 1'b0;
      imem_req    <= 1'b0;
      alu_src     <= 1'b0;
      alu_op      <= 2'b00;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
      reg_write   <= 1'b0;
      pc_write_q  <= 1'b0;
      pc_sel_q    <= 2'b00;
      wb_sel      <= 2'b00;
      br_exec     <= 1'b0;
    end else begin
      imem_req   <= 1'b0;
      alu_src    <= 1'b0;
      alu_op     <= 2'b00;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_write  <= 1'b0;
      pc_write_q <= 1'b0;
      pc_sel_q   <= 2'b00;
      wb_sel     <= 2'b00;
      br_exec    <= 1'b0;
      if (pc_write) retired_cnt <= retired_cnt + CNT_W'(1);

      unique case (state)
        FETCH: begin
          // The first cycle out of reset only raises imem_req; fetches are accepted once it is up.
          if (imem_req && imem_ready) begin
            op_q  <= opcode;
            state <= DECODE;
          end else if (imem_req && timeout_hit) begin
            state   <= TRAP;
            trap    <= 1'b1;
            bus_err <= 1'b1;
          end else begin
            imem_req <= 1'b1;
            if (imem_req) wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DECODE: begin
          if (!stall) begin
            if (legal) begin
              state   <= EXEC;
              alu_src <= is_load | is_store | is_imm;
              alu_op  <= alu_op_n;
              br_exec <= is_br;
            end else begin
              state <= TRAP;
              trap  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (is_br) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end else if (is_load || is_store) begin
            state     <= MEM;
            mem_read  <= is_load;
            mem_write <= is_store;
            wait_cnt  <= '0;
          end else begin
            state      <= WB;
            reg_write  <= 1'b1;
            wb_sel     <= wb_sel_n;
            pc_sel_q   <= pc_sel_n;
            pc_write_q <= 1'b1;
          end
        end
        MEM: begin
          if (dmem_ready) begin
            if (is_load) begin
              state      <= WB;
              reg_write  <= 1'b1;
              mem_to_reg <= 1'b1;
              wb_sel     <= wb_sel_n;
              pc_sel_q   <= pc_sel_n;
              pc_write_q <= 1'b1;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
              wait_cnt <= '0;
            end
          end else if (timeout_hit) begin
            state   <= TRAP;
            trap    <= 1'b1;
            bus_err <= 1'b1;
          end else begin
            mem_read  <= is_load;
            mem_write <= is_store;
            wait_cnt  <= wait_cnt + WAIT_W'(1);
          end
        end
        WB: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end
        TRAP: begin
          state <= TRAP;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-instruction expectations are queued at drive time
// and compared at retire; trap, timeout, counter wrap and reset-abort are checked inline.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic       imem_ready, dmem_ready, stall, branch_taken;
  logic       imem_req, ir_write, alu_src, mem_read, mem_write, mem_to_reg;
  logic       reg_write, pc_write, instr_done, trap, bus_err;
  logic [1:0] alu_op, pc_sel, wb_sel;
  logic [3:0] retired_cnt;

  typedef struct {
    int         cycles;
    int         memCycles;
    int         irCount;
    logic [1:0] pcSel;
    logic [1:0] wbSel;
    logic [1:0] aluOp;
    logic       regWr;
    logic       memToReg;
    logic       aluSrc;
    logic       done;
  } res_t;

  res_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   cntModel = 0;

  multicycle_ctrl_fsm #(.OPC_W(7), .TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .stall(stall), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_write(ir_write), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .pc_write(pc_write), .pc_sel(pc_sel), .wb_sel(wb_sel),
    .instr_done(instr_done), .retired_cnt(retired_cnt), .trap(trap), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input res_t o);
    res_t e;
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkVal("retire_pulse", o.done, e.done);
    checkVal("cycle_count", o.cycles, e.cycles);
    checkVal("pc_sel", o.pcSel, e.pcSel);
    checkVal("reg_write_seen", o.regWr, e.regWr);
    checkVal("mem_to_reg", o.memToReg, e.memToReg);
    checkVal("wb_sel", o.wbSel, e.wbSel);
    checkVal("mem_strobe_cycles", o.memCycles, e.memCycles);
    checkVal("alu_src", o.aluSrc, e.aluSrc);
    checkVal("alu_op", o.aluOp, e.aluOp);
    checkVal("ir_write_pulses", o.irCount, e.irCount);
    checkVal("no_bus_err", bus_err, 1'b0);
    checkVal("no_trap", trap, 1'b0);
  endtask

  // Drives one instruction from its first FETCH cycle to retire; expectation is queued up front.
  task automatic applyStimulus(input logic [6:0] op, input logic taken, input int dwait,
                               input int stallN, input int fetchWait);
    res_t e, o;
    int   fc, memc, g;
    bit   isLd, isSt, isBr;
    isLd = (op == OP_LOAD);
    isSt = (op == OP_STORE);
    isBr = (op == OP_BR);
    e.cycles    = (isBr ? 3 : isLd ? 5 : 4) + ((isLd || isSt) ? dwait : 0) + stallN + fetchWait;
    e.memCycles = (isLd || isSt) ? dwait + 1 : 0;
    e.irCount   = 1;
    e.regWr     = !(isBr || isSt);
    e.memToReg  = isLd;
    e.wbSel     = (op == OP_JAL || op == OP_JALR) ? 2'b01 : (op == OP_LUI) ? 2'b10 :
                  (op == OP_AUIPC) ? 2'b11 : 2'b00;
    e.pcSel     = isBr ? {1'b0, taken} : (op == OP_JAL) ? 2'b10 : (op == OP_JALR) ? 2'b11 : 2'b00;
    e.aluSrc    = isLd || isSt || (op == OP_IMM);
    e.aluOp     = (op == OP_R) ? 2'b10 : (op == OP_IMM) ? 2'b11 : isBr ? 2'b01 : 2'b00;
    e.done      = 1'b1;
    sb.push_back(e);

    o.cycles = 0; o.memCycles = 0; o.irCount = 0; o.pcSel = 2'bxx; o.wbSel = 2'b00;
    o.aluOp = 2'bxx; o.regWr = 1'b0; o.memToReg = 1'b0; o.aluSrc = 1'bx; o.done = 1'b0;
    fc = 0; memc = 0; g = 0;

    @(negedge clk);
    while (!imem_req && g < 4) begin
      @(negedge clk);
      g++;
    end
    for (int k = 0; k < 80 && !o.done; k++) begin
      if (k > 0) @(negedge clk);
      o.cycles++;
      if (imem_req) fc++;
      if (mem_read || mem_write) begin
        memc++;
        o.memCycles++;
      end
      opcode       = op;
      branch_taken = taken;
      imem_ready   = imem_req && (fc > fetchWait);
      dmem_ready   = (mem_read || mem_write) && (memc > dwait);
      stall        = (o.cycles >= fetchWait + 2) && (o.cycles < fetchWait + 2 + stallN);
      #1;
      if (o.cycles == 1) checkVal("retired_cnt", retired_cnt, cntModel[3:0]);
      if (ir_write) o.irCount++;
      if (o.cycles == fetchWait + stallN + 3) begin
        o.aluSrc = alu_src;
        o.aluOp  = alu_op;
      end
      if (reg_write) begin
        o.regWr    = 1'b1;
        o.memToReg = mem_to_reg;
        o.wbSel    = wb_sel;
      end
      if (pc_write) begin
        o.done  = instr_done;
        o.pcSel = pc_sel;
        if (!instr_done) checkVal("instr_done_with_pc_write", instr_done, 1'b1);
      end
    end
    if (!pc_write) checkVal("retire_within_bound", 32'd0, 32'd1);
    cntModel = (cntModel + 1) % 16;
    checkOutput(o);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkVal("reset_trap", trap, 1'b0);
    checkVal("reset_bus_err", bus_err, 1'b0);
    checkVal("reset_cnt", retired_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cntModel = 0;
  endtask

  initial begin
    logic [6:0] fill [6];
    fill[0] = OP_R; fill[1] = OP_IMM; fill[2] = OP_LUI;
    fill[3] = OP_AUIPC; fill[4] = OP_JAL; fill[5] = OP_STORE;

    rst_n = 1'b0; opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    stall = 1'b0; branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkVal("reset_imem_req", imem_req, 1'b0);
    checkVal("reset_pc_write", pc_write, 1'b0);
    checkVal("reset_reg_write", reg_write, 1'b0);
    checkVal("reset_trap", trap, 1'b0);
    checkVal("reset_cnt", retired_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(OP_R,     1'b0, 0, 0, 0);
    applyStimulus(OP_LOAD,  1'b0, 3, 0, 0);
    applyStimulus(OP_BR,    1'b1, 0, 0, 0);
    applyStimulus(OP_BR,    1'b0, 0, 0, 0);
    applyStimulus(OP_STORE, 1'b0, 0, 0, 0);
    applyStimulus(OP_IMM,   1'b0, 0, 0, 0);
    applyStimulus(OP_JAL,   1'b1, 0, 0, 0);
    applyStimulus(OP_JALR,  1'b0, 0, 0, 0);
    applyStimulus(OP_LUI,   1'b0, 0, 0, 0);
    applyStimulus(OP_AUIPC, 1'b0, 0, 0, 0);
    applyStimulus(OP_R,     1'b0, 0, 2, 0);
    for (int i = 0; i < 6; i++) applyStimulus(fill[i], 1'b0, i % 2, 0, 0);
    // 18th instruction starts with 17 retired, so the 4-bit counter must read 1.
    applyStimulus(OP_R,     1'b0, 0, 0, 0);

    // Reset in the middle of a LOAD's MEM phase.
    @(negedge clk);
    opcode = OP_LOAD; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 10 && !mem_read; k++) @(negedge clk);
    checkVal("mid_mem_reached", mem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    checkVal("abort_mem_read", mem_read, 1'b0);
    checkVal("abort_cnt", retired_cnt, 4'd0);
    checkVal("abort_imem_req", imem_req, 1'b0);
    imem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cntModel = 0;

    // Ready arriving on the 16th fetch cycle still wins over the timeout.
    applyStimulus(OP_R, 1'b0, 0, 0, 15);

    // Fetch that never completes: bus error after 16 waiting cycles.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      imem_ready = 1'b0;
      #1;
      if (k == 1) checkVal("timeout_fetch_req", imem_req, 1'b1);
      if (k == 16) checkVal("timeout_not_yet", bus_err, 1'b0);
    end
    @(negedge clk);
    #1;
    checkVal("timeout_bus_err", bus_err, 1'b1);
    checkVal("timeout_trap", trap, 1'b1);
    checkVal("timeout_imem_req", imem_req, 1'b0);
    checkVal("timeout_cnt_frozen", retired_cnt, 4'd1);
    resetPulse();

    // Illegal opcode traps after DECODE and then ignores all inputs.
    opcode = OP_BAD; imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkVal("illegal_trap", trap, 1'b1);
    checkVal("illegal_bus_err", bus_err, 1'b0);
    dmem_ready = 1'b1; branch_taken = 1'b1; opcode = OP_R;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkVal("trap_strobes_low",
               {imem_req, ir_write, mem_read, mem_write, reg_write, pc_write, instr_done,
                mem_to_reg, alu_src}, 9'd0);
    end
    checkVal("trap_cnt_frozen", retired_cnt, 4'd0);
    checkVal("trap_sticky", trap, 1'b1);
    dmem_ready = 1'b0; branch_taken = 1'b0;
    resetPulse();
    applyStimulus(OP_R, 1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
